// File: rtl/dac_pkg.sv
// Shared types and constants for the dual-channel SPI DAC slot peripheral.
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD
  } tx_state_t;

  localparam logic [1:0] ADDR_CH_A = 2'd0;
  localparam logic [1:0] ADDR_CH_B = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;

  localparam int FRAME_W = 16;
  localparam int PD_LSB  = 12;
  localparam int PD_W    = 2;

  function automatic logic [FRAME_W-1:0] make_frame(input logic [PD_W-1:0]   pd,
                                                    input logic [PD_LSB-1:0] code);
    return {2'b00, pd, code};
  endfunction

endpackage

// File: rtl/dac_if.sv
// MMIO slot bus between the processor and the DAC core.
interface dac_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  reg_addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, reg_addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, reg_addr, wr_data, output rd_data);
endinterface

// File: rtl/dac_spi_tx.sv
// Serialises two 16-bit DAC frames in lockstep on shared SCLK/SYNC with registered pins.
// state    | meaning
// ST_IDLE  | sync high, sclk high, waiting for start
// ST_SETUP | sync low, bit 15 on data lines, CLK_DIV cycles before first fall
// ST_SHIFT | 16 bits, sclk low then high for CLK_DIV cycles each
// ST_HOLD  | sync high for 2*CLK_DIV cycles; restarts directly if start is high
module dac_spi_tx
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [FRAME_W-1:0] frame_a,
  input  logic [FRAME_W-1:0] frame_b,
  output logic               busy,
  output logic               frame_done,
  output logic               dac_sclk,
  output logic               dac_sync_n,
  output logic               dac_d0,
  output logic               dac_d1
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(2 * CLK_DIV - 1);

  tx_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [3:0]         bit_cnt, bit_cnt_nxt;
  logic [FRAME_W-1:0] sh_a, sh_a_nxt, sh_b, sh_b_nxt;
  logic               sclk, sclk_nxt, sync_n, sync_n_nxt;
  logic               d0, d0_nxt, d1, d1_nxt;
  logic               load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
      sclk    <= 1'b1;
      sync_n  <= 1'b1;
      d0      <= 1'b0;
      d1      <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      sh_a    <= sh_a_nxt;
      sh_b    <= sh_b_nxt;
      sclk    <= sclk_nxt;
      sync_n  <= sync_n_nxt;
      d0      <= d0_nxt;
      d1      <= d1_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_cnt_nxt = bit_cnt;
    sh_a_nxt    = sh_a;
    sh_b_nxt    = sh_b;
    sclk_nxt    = sclk;
    sync_n_nxt  = sync_n;
    d0_nxt      = d0;
    d1_nxt      = d1;
    load        = 1'b0;
    frame_done  = (state == ST_HOLD) && (cnt == '0);

    case (state)
      ST_IDLE: load = start;
      ST_SETUP: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else begin
          state_nxt   = ST_SHIFT;
          cnt_nxt     = HALF_CNT;
          sclk_nxt    = 1'b0;
          bit_cnt_nxt = 4'd15;
        end
      end
      ST_SHIFT: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else if (!sclk) begin
          // rising edge: present the next bit so it is stable by the next fall
          sclk_nxt = 1'b1;
          cnt_nxt  = HALF_CNT;
          sh_a_nxt = sh_a << 1;
          sh_b_nxt = sh_b << 1;
          d0_nxt   = sh_a[FRAME_W-2];
          d1_nxt   = sh_b[FRAME_W-2];
        end else if (bit_cnt == 4'd0) begin
          state_nxt  = ST_HOLD;
          sync_n_nxt = 1'b1;
          cnt_nxt    = HOLD_CNT;
          d0_nxt     = 1'b0;
          d1_nxt     = 1'b0;
        end else begin
          sclk_nxt    = 1'b0;
          cnt_nxt     = HALF_CNT;
          bit_cnt_nxt = bit_cnt - 4'd1;
        end
      end
      ST_HOLD: begin
        if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
        else if (start) load = 1'b1;
        else state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (load) begin
      state_nxt  = ST_SETUP;
      cnt_nxt    = HALF_CNT;
      sh_a_nxt   = frame_a;
      sh_b_nxt   = frame_b;
      sclk_nxt   = 1'b1;
      sync_n_nxt = 1'b0;
      d0_nxt     = frame_a[FRAME_W-1];
      d1_nxt     = frame_b[FRAME_W-1];
    end
  end

  assign busy       = (state != ST_IDLE);
  assign dac_sclk   = sclk;
  assign dac_sync_n = sync_n;
  assign dac_d0     = d0;
  assign dac_d1     = d1;

endmodule

// File: rtl/dac_core.sv
// Slot-bus DAC peripheral: channel code registers, start/pending/done control, status readback.
module dac_core
  import dac_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = 12
) (
  input  logic clk,
  input  logic reset,
  dac_if.slave bus,
  output logic dac_sclk,
  output logic dac_sync_n,
  output logic dac_d0,
  output logic dac_d1
);

  logic [DATA_W-1:0] code_a, code_b;
  logic [PD_W-1:0]   pd_a, pd_b;
  logic              pending, done, start_q;
  logic              tx_busy, tx_start, frame_done, busy;
  logic              wr_en, start_wr, pend_req;
  logic [1:0]        addr;
  logic [31:0]       rd_mux;

  assign addr     = bus.reg_addr[1:0];
  assign wr_en    = bus.cs & bus.write;
  assign start_wr = wr_en && (addr == ADDR_CTRL) && bus.wr_data[0];
  assign busy     = tx_busy | pending;
  // a start landing on the very cycle a frame finishes must still chain a new frame
  assign pend_req = pending | (start_wr & busy);
  assign tx_start = start_q | pend_req;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      code_a  <= '0;
      code_b  <= '0;
      pd_a    <= '0;
      pd_b    <= '0;
      pending <= 1'b0;
      done    <= 1'b0;
      start_q <= 1'b0;
    end else begin
      start_q <= start_wr & ~busy;
      if (wr_en && addr == ADDR_CH_A) begin
        code_a <= bus.wr_data[DATA_W-1:0];
        pd_a   <= bus.wr_data[PD_LSB+PD_W-1:PD_LSB];
      end
      if (wr_en && addr == ADDR_CH_B) begin
        code_b <= bus.wr_data[DATA_W-1:0];
        pd_b   <= bus.wr_data[PD_LSB+PD_W-1:PD_LSB];
      end
      pending <= frame_done ? 1'b0 : pend_req;
      if (frame_done && !pend_req) done <= 1'b1;
      else if (start_wr) done <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      ADDR_CH_A: rd_mux = 32'({pd_a, code_a});
      ADDR_CH_B: rd_mux = 32'({pd_b, code_b});
      ADDR_CTRL: rd_mux = {30'b0, done, busy};
      default:   rd_mux = '0;
    endcase
  end

  assign bus.rd_data = rd_mux;

  logic unused_bus;
  assign unused_bus = &{1'b0, bus.read, bus.reg_addr[4:2], bus.wr_data[31:PD_LSB+PD_W]};

  dac_spi_tx #(.CLK_DIV(CLK_DIV)) u_tx (
    .clk        (clk),
    .reset      (reset),
    .start      (tx_start),
    .frame_a    (make_frame(pd_a, code_a)),
    .frame_b    (make_frame(pd_b, code_b)),
    .busy       (tx_busy),
    .frame_done (frame_done),
    .dac_sclk   (dac_sclk),
    .dac_sync_n (dac_sync_n),
    .dac_d0     (dac_d0),
    .dac_d1     (dac_d1)
  );

endmodule

// File: tb/tb_dac_core.sv
// Scoreboard bench for dac_core: two instances (CLK_DIV=2 and CLK_DIV=1) with a shared reset.
module tb_dac_core;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_if bus0();
  dac_if bus1();

  logic [1:0]       cs_v, wr_v;
  logic [1:0][4:0]  addr_v;
  logic [1:0][31:0] wd_v, rd_v;
  logic [1:0]       sclk, sync_n, d0, d1;

  assign bus0.cs = cs_v[0];       assign bus1.cs = cs_v[1];
  assign bus0.write = wr_v[0];    assign bus1.write = wr_v[1];
  assign bus0.read = ~wr_v[0];    assign bus1.read = ~wr_v[1];
  assign bus0.reg_addr = addr_v[0]; assign bus1.reg_addr = addr_v[1];
  assign bus0.wr_data = wd_v[0];  assign bus1.wr_data = wd_v[1];
  assign rd_v[0] = bus0.rd_data;  assign rd_v[1] = bus1.rd_data;

  dac_core #(.CLK_DIV(2), .DATA_W(12)) dut0 (
    .clk(clk), .reset(rst_n), .bus(bus0),
    .dac_sclk(sclk[0]), .dac_sync_n(sync_n[0]), .dac_d0(d0[0]), .dac_d1(d1[0]));

  dac_core #(.CLK_DIV(1), .DATA_W(12)) dut1 (
    .clk(clk), .reset(rst_n), .bus(bus1),
    .dac_sclk(sclk[1]), .dac_sync_n(sync_n[1]), .dac_d0(d0[1]), .dac_d1(d1[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no expected value queued", name);
  endtask

  // expected frames {frame_a, frame_b} and busy run lengths per instance
  logic [31:0] qf0[$], qf1[$];
  int          qb0[$], qb1[$];

  int          nb[2], run[2], gap[2];
  logic [15:0] sa[2], sb[2];
  logic        pscl[2], psync[2], pbusy[2];

  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        nb[i] = 0; run[i] = 0; gap[i] = 0;
        pscl[i] = 1'b1; psync[i] = 1'b1; pbusy[i] = 1'b0;
      end else begin
        logic        cb;
        logic [31:0] ef;
        int          eb;
        if (pscl[i] && !sclk[i] && !sync_n[i]) begin
          sa[i] = {sa[i][14:0], d0[i]};
          sb[i] = {sb[i][14:0], d1[i]};
          nb[i]++;
          if (nb[i] == 16) begin
            nb[i] = 0;
            if (i == 0) begin
              if (qf0.size() == 0) fail_now("frame0_unexpected");
              else begin ef = qf0.pop_front(); chk("frame0", {sa[i], sb[i]}, ef); end
            end else begin
              if (qf1.size() == 0) fail_now("frame1_unexpected");
              else begin ef = qf1.pop_front(); chk("frame1", {sa[i], sb[i]}, ef); end
            end
          end
        end
        cb = (addr_v[i] == 5'd2) ? rd_v[i][0] : pbusy[i];
        if (cb) begin
          run[i]++;
          if (sync_n[i]) gap[i]++;
        end else begin
          if (run[i] > 0) begin
            if (i == 0) begin
              if (qb0.size() == 0) fail_now("busy0_unexpected");
              else begin eb = qb0.pop_front(); chk("busy_len0", run[i], eb); end
            end else begin
              if (qb1.size() == 0) fail_now("busy1_unexpected");
              else begin eb = qb1.pop_front(); chk("busy_len1", run[i], eb); end
            end
            if (addr_v[i] == 5'd2) chk("status_after_frame", rd_v[i], 32'h2);
          end
          run[i] = 0;
          gap[i] = 0;
        end
        if (psync[i] && !sync_n[i]) begin
          if (gap[i] > 0) chk("sync_gap", gap[i], (i == 0) ? 4 : 2);
          gap[i] = 0;
        end
        pscl[i] = sclk[i]; psync[i] = sync_n[i]; pbusy[i] = cb;
      end
    end
    if (!rst_n) begin
      qf0.delete(); qf1.delete(); qb0.delete(); qb1.delete();
    end
  end

  task automatic wr(input int d, input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    cs_v[d] = 1'b1; wr_v[d] = 1'b1; addr_v[d] = {3'b0, a}; wd_v[d] = v;
    @(negedge clk);
    cs_v[d] = 1'b0; wr_v[d] = 1'b0; addr_v[d] = 5'd2; wd_v[d] = '0;
  endtask

  task automatic rd_chk(input string name, input int d, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    addr_v[d] = {3'b0, a};
    #1;
    chk(name, rd_v[d], exp);
    addr_v[d] = 5'd2;
  endtask

  task automatic wait_idle(input int d, input int max_cyc);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (rd_v[d][0] && n < max_cyc);
    chk("wait_idle_timeout", {31'b0, rd_v[d][0]}, 32'h0);
  endtask

  task automatic chk_pins(input string name, input int d);
    chk(name, {28'b0, sclk[d], sync_n[d], d0[d], d1[d]}, 32'hC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    cs_v = '0; wr_v = '0; wd_v = '0;
    addr_v[0] = 5'd2; addr_v[1] = 5'd2;

    #12;
    chk_pins("reset_pins0", 0);
    chk_pins("reset_pins1", 1);
    chk("reset_status0", rd_v[0], 32'h0);
    chk("reset_status1", rd_v[1], 32'h0);
    #11 rst_n = 1'b1;

    rd_chk("reset_ch_a", 0, 2'd0, 32'h0);

    // basic frame, CLK_DIV=2
    wr(0, 2'd0, 32'h0ABC);
    wr(0, 2'd1, 32'h0123);
    rd_chk("rd_ch_b", 0, 2'd1, 32'h0123);
    qf0.push_back(32'h0ABC_0123); qb0.push_back(70);
    wr(0, 2'd2, 32'h1);
    chk("sync_before_T1", {31'b0, sync_n[0]}, 32'h1);
    @(negedge clk);
    chk("sync_at_T1", {31'b0, sync_n[0]}, 32'h0);
    chk("sclk_setup", {31'b0, sclk[0]}, 32'h1);
    chk("busy_at_T1", rd_v[0], 32'h1);
    wait_idle(0, 200);
    rd_chk("status_done", 0, 2'd2, 32'h2);

    // power-down field, and a CH write during the frame affecting only the next one
    wr(0, 2'd0, 32'h1FFF);
    rd_chk("rd_ch_a_pd", 0, 2'd0, 32'h1FFF);
    wr(0, 2'd1, 32'h0);
    qf0.push_back(32'h1FFF_0000); qb0.push_back(70);
    wr(0, 2'd2, 32'h1);
    repeat (10) @(negedge clk);
    wr(0, 2'd0, 32'h0555);
    wait_idle(0, 200);
    qf0.push_back(32'h0555_0000); qb0.push_back(70);
    wr(0, 2'd2, 32'h1);
    wait_idle(0, 200);

    // two starts during a frame merge into exactly one extra frame
    wr(0, 2'd0, 32'h0111);
    wr(0, 2'd1, 32'h0222);
    qf0.push_back(32'h0111_0222); qf0.push_back(32'h0333_0222); qb0.push_back(140);
    wr(0, 2'd2, 32'h1);
    repeat (10) @(negedge clk);
    wr(0, 2'd0, 32'h0333);
    wr(0, 2'd2, 32'h1);
    wr(0, 2'd2, 32'h1);
    repeat (60) @(negedge clk);
    rd_chk("status_second_frame", 0, 2'd2, 32'h1);
    wait_idle(0, 300);
    rd_chk("status_after_merge", 0, 2'd2, 32'h2);

    // CLK_DIV=1 instance
    wr(1, 2'd0, 32'h2FA5);
    wr(1, 2'd1, 32'h3C3C);
    rd_chk("rd_ch_a_dut1", 1, 2'd0, 32'h2FA5);
    qf1.push_back(32'h2FA5_3C3C); qb1.push_back(35);
    wr(1, 2'd2, 32'h1);
    wait_idle(1, 100);
    wr(1, 2'd0, 32'h0800);
    wr(1, 2'd1, 32'h0001);
    qf1.push_back(32'h0800_0001); qb1.push_back(35);
    wr(1, 2'd2, 32'h1);
    wait_idle(1, 100);

    repeat (3) @(negedge clk);
    chk("q_frames0_drained", qf0.size(), 0);
    chk("q_busy0_drained", qb0.size(), 0);
    chk("q_frames1_drained", qf1.size(), 0);
    chk("q_busy1_drained", qb1.size(), 0);

    // reset mid-frame aborts immediately
    wr(0, 2'd0, 32'h0FFF);
    wr(0, 2'd1, 32'h0FFF);
    wr(0, 2'd2, 32'h1);
    repeat (12) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_pins("midframe_reset_pins", 0);
    chk("midframe_reset_status", rd_v[0], 32'h0);
    #20;
    @(negedge clk);
    #1 rst_n = 1'b1;
    rd_chk("reset_clears_ch_a", 0, 2'd0, 32'h0);
    repeat (5) @(negedge clk);
    chk_pins("idle_after_reset", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
